// File: rtl/iir_biquad_cascade_tdm_if.sv
// Sample and coefficient ports of the time-multiplexed biquad cascade.
// Master drives samples/coefficients, slave is the filter.
interface iir_biquad_cascade_tdm_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] x;
  logic                    out_valid;
  logic signed [WIDTH-1:0] y;
  logic                    coef_we;
  logic [AW-1:0]           coef_addr;
  logic signed [WIDTH-1:0] coef_data;
  logic                    coef_err;

  modport master (
    output in_valid, x, coef_we, coef_addr, coef_data,
    input  in_ready, out_valid, y, coef_err
  );

  modport slave (
    input  in_valid, x, coef_we, coef_addr, coef_data,
    output in_ready, out_valid, y, coef_err
  );
endinterface

// File: rtl/iir_biquad_cascade_tdm.sv
// Cascade of DF-II biquads sharing one multiplier/accumulator,
// one MAC step per cycle, with saturation and coefficient port.
module iir_biquad_cascade_tdm #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 20,
  parameter int SECTIONS = 4,
  parameter int GAIN     = 6
) (
  input logic                   clk,
  input logic                   rst,
  iir_biquad_cascade_tdm_if.slave bus
);

  localparam int NCOEF = 5 * SECTIONS;
  localparam int CAW   = $clog2(NCOEF);
  localparam int SW    = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam int NZ    = 1 << SW;
  localparam int AW    = 2 * WIDTH + 4;
  localparam int PW    = 2 * WIDTH;

  localparam logic signed [AW-1:0] MAXA =
    {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MINA =
    {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAXW =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINW =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic signed [WIDTH-1:0] coef_arr_t [NCOEF];

  function automatic coef_arr_t coef_init();
    coef_arr_t c;
    for (int i = 0; i < NCOEF; i++) begin
      c[i] = '0;
      if (i % 5 == 0) c[i][FRAC] = 1'b1;
    end
    return c;
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(
    input logic signed [AW-1:0] v
  );
    if (v > MAXA) return MAXW;
    else if (v < MINA) return MINW;
    else return v[WIDTH-1:0];
  endfunction

  state_t                  state_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    coef_err_q;
  logic signed [WIDTH-1:0] y_q;
  logic signed [WIDTH-1:0] xs_q;
  logic signed [WIDTH-1:0] w_q;
  logic signed [AW-1:0]    acc_q;
  logic [SW-1:0]           s_q;
  logic [2:0]              k_q;
  logic signed [WIDTH-1:0] z1_q [NZ];
  logic signed [WIDTH-1:0] z2_q [NZ];

  // Power-up pass-through; rst deliberately leaves coefficients alone.
  coef_arr_t coef_q = coef_init();

  logic [2:0]              ksel;
  logic [CAW-1:0]          cidx;
  logic signed [WIDTH-1:0] cmul;
  logic signed [WIDTH-1:0] dmul;
  logic signed [WIDTH-1:0] w_d;
  logic signed [WIDTH-1:0] xs_d;
  logic signed [WIDTH-1:0] y_d;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    prod_x;
  logic signed [AW-1:0]    xs_ext;
  logic signed [AW-1:0]    base;
  logic signed [AW-1:0]    acc_d;
  logic                    sub;
  logic                    last;
  logic                    addr_ok;
  logic                    wr_ok;

  // Step k uses coefficient a1,a2,b0,b1,b2 in that order.
  always_comb begin
    ksel   = (k_q >= 3'd2) ? k_q - 3'd2 : k_q + 3'd3;
    cidx   = CAW'(5 * 32'(s_q) + 32'(ksel));
    cmul   = coef_q[cidx];
    xs_ext = {{(AW-WIDTH){xs_q[WIDTH-1]}}, xs_q};
    w_d    = sat(acc_q >>> FRAC);
    dmul   = w_d;
    sub    = 1'b0;
    base   = acc_q;
    unique case (k_q)
      3'd0: begin
        dmul = z1_q[s_q];
        sub  = 1'b1;
        base = xs_ext <<< FRAC;
      end
      3'd1: begin
        dmul = z2_q[s_q];
        sub  = 1'b1;
      end
      3'd2: begin
        dmul = w_d;
        base = '0;
      end
      3'd3: dmul = z1_q[s_q];
      default: dmul = z2_q[s_q];
    endcase
    prod   = cmul * dmul;
    prod_x = {{(AW-PW){prod[PW-1]}}, prod};
    acc_d  = sub ? base - prod_x : base + prod_x;
    xs_d   = sat(acc_d >>> FRAC);
    y_d    = sat(xs_ext <<< GAIN);
  end

  assign last    = (s_q == SW'(SECTIONS - 1));
  assign addr_ok = (32'(bus.coef_addr) < 32'(NCOEF));
  assign wr_ok   = bus.coef_we && addr_ok && (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) coef_q[bus.coef_addr] <= bus.coef_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      coef_err_q  <= 1'b0;
      y_q         <= '0;
      xs_q        <= '0;
      w_q         <= '0;
      acc_q       <= '0;
      s_q         <= '0;
      k_q         <= '0;
      for (int i = 0; i < NZ; i++) begin
        z1_q[i] <= '0;
        z2_q[i] <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      coef_err_q  <= bus.coef_we && !wr_ok;
      unique case (state_q)
        IDLE: begin
          if (in_ready_q && bus.in_valid) begin
            xs_q       <= bus.x;
            s_q        <= '0;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          if (k_q == 3'd2) w_q <= w_d;
          if (k_q == 3'd4) begin
            z2_q[s_q] <= z1_q[s_q];
            z1_q[s_q] <= w_q;
            xs_q      <= xs_d;
            k_q       <= '0;
            if (last) state_q <= DONE;
            else s_q <= s_q + 1'b1;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        DONE: begin
          y_q         <= y_d;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.coef_err  = coef_err_q;

endmodule

// File: doc/iir_biquad_cascade_tdm.md
Name: iir_biquad_cascade_tdm

Overview:
- Parametrised cascade of SECTIONS second-order IIR sections, Direct Form II, Q(FRAC) fixed point.
- One shared multiplier/accumulator is time-multiplexed across all sections and taps.
- Adds a valid/ready sample handshake, a run-time coefficient write port, and saturation. The existing single-section filter has none of these.
- Sits between the sample source and the decoder. Replaces hand-chained single biquads.

Parameters:
- WIDTH, 32, sample and coefficient width (signed).
- FRAC, 20, fractional bits of coefficients; 1.0 = 2^FRAC.
- SECTIONS, 4, number of cascaded biquads (1..16).
- GAIN, 6, final left shift applied to the cascade output.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  x is valid.
- in_ready  out  1  block can accept a sample.
- x  in  WIDTH  signed input sample.
- out_valid  out  1  one-cycle pulse, y valid.
- y  out  WIDTH  signed output sample, held until the next out_valid.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(5*SECTIONS)  address = 5*section + k, with k: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
- coef_data  in  WIDTH  signed coefficient.
- coef_err  out  1  one-cycle pulse: write rejected.

Behaviour:
- **Reset:**
  - in_ready=1, out_valid=0, y=0, coef_err=0, FSM=IDLE.
  - All z1[s], z2[s] = 0.
  - Coefficients are NOT cleared by rst. Power-up value: b0=2^FRAC, all others 0, i.e. pass-through.
- **FSM states:** IDLE, RUN, DONE.
  - IDLE: in_ready=1. in_valid&&in_ready at an edge captures x into xs, clears section/step counters s=0, k=0, and moves to RUN.
  - RUN: in_ready=0. Performs one MAC step per cycle; per-step operations are listed below.
  - DONE: in_ready=0, for one cycle. Registers y = sat(xs <<< GAIN) and pulses out_valid. Returns to IDLE.
- **Per-section steps in RUN (five cycles per section):**
  - k0: acc = (xs<<<FRAC) − a1·z1[s].
  - k1: acc -= a2·z2[s].
  - k2: w = sat(acc>>>FRAC); wreg=w; acc = b0·w.
  - k3: acc += b1·z1[s].
  - k4: acc += b2·z2[s]. On this edge: z2[s]←z1[s], z1[s]←wreg, xs←sat(acc_final>>>FRAC). Then s++ and k=0. After s=SECTIONS−1, go to DONE.
- **Arithmetic:**
  - Accumulator width is 2*WIDTH+4; it never wraps.
  - >>> is arithmetic (floor).
  - sat() clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - The GAIN shift is saturated; it must not wrap.
  - z1/z2 are stored at WIDTH bits, already saturated.
- **Latency:**
  - Acceptance edge is edge 0. out_valid is high in the cycle after edge 5*SECTIONS+1.
  - Throughput: one sample per 5*SECTIONS+2 cycles.
  - in_ready rises again the cycle after the out_valid cycle.
- **Coefficient writes:**
  - coef_we in IDLE: written at the edge. If in_valid is accepted at that same edge, the new coefficient is already used for that sample.
  - coef_we in RUN or DONE: ignored; coef_err pulses the next cycle.
  - coef_addr ≥ 5*SECTIONS: ignored; coef_err pulses.
- **rst mid-RUN:** aborts the sample. No out_valid, state cleared as above, coefficients retained.
- **in_valid while in_ready=0:** ignored. The source must hold x and in_valid until accepted.

Test Plan:
1. **Pass-through.** SECTIONS=4, GAIN=0, default coefficients. Send x=1000, then x=−7.
   - Expect y=1000, then y=−7.
   - out_valid exactly 21 cycles after each acceptance.
   - in_ready low for 22 cycles.
2. **Recursive impulse.** SECTIONS=1, GAIN=0. Write a1=−524288 (−0.5) via the port. Feed 1000, 0, 0, 0.
   - Expect y=1000, 500, 250, 125.
3. **FIR taps.** SECTIONS=1, GAIN=0. Write b0=b1=b2=2^20. Feed 3, 0, 0, 0.
   - Expect y=3, 3, 3, 0.
4. **Saturation.** SECTIONS=1, GAIN=0, b0=4·2^20. Feed x=2^30.
   - Expect y=2^31−1. Feed x=−2^30: expect y=−2^31.
   - Default GAIN=6 with x=2^26 in pass-through: expect y=2^31−1.
5. **Write rejection.** Pulse coef_we during RUN, and separately with coef_addr=5*SECTIONS.
   - Expect a coef_err pulse each time and coefficients unchanged (a re-run of scenario 1 still passes).
6. **Reset mid-run.** Assert rst at step k2 of section 2 after a 1000 impulse with a1=−0.5.
   - Expect no out_valid; in_ready=1 the next cycle.
   - Next input 0 gives y=0, proving state was cleared.
   - Then feed 1000: expect y=1000 (coefficients retained).
